fft_input_loader: RTL and testbench

Capture front end for the spectrum analyzer. Accepts a strobed stream of signed ADC samples, sign-extends each to RAM width, and writes one 1024-point frame into the real-input dual-port data RAM through its port A in FFT (bit-reversed) order. It then raises `frame_ready` to the FFT engine and holds off the next frame until the engine acknowledges. Samples that arrive while the block cannot accept them are dropped and counted.

---
 rtl/fft_input_loader.sv | 156 +++++++++++++++
 tb/tb_fft_input_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// +----------------------------------------------------------------------------+
// | fft_input_loader                                                           |
// | Captures one frame of ADC samples into the FFT data RAM (port A).          |
// | Macro FFT_LOADER_BITREV_EN: bit-reversed write addresses when defined,     |
// | natural order otherwise.                                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_input_loader #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int RAM_WIDTH     = 18,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic [SAMPLE_WIDTH-1:0]  sample_in,
  input  logic                     sample_valid,
  input  logic                     fft_ack,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_din,
  output logic                     ram_we,
  output logic                     frame_ready,
  output logic                     busy,
  output logic [RAM_ADDR_BITS:0]   fill_count,
  output logic [15:0]              drop_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [RAM_ADDR_BITS:0] c_LAST = {1'b0, {RAM_ADDR_BITS{1'b1}}};

  logic [1:0]               state_q, state_d;
  logic [RAM_ADDR_BITS:0]   fill_q, fill_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     pend_din_q, pend_din_d;
  logic                     pend_q, pend_d;
  logic [RAM_WIDTH-1:0]     din_q;
  logic                     we_q;
  logic [15:0]              drop_q, drop_d;

  logic [RAM_WIDTH-1:0]     w_sext;
  logic [RAM_ADDR_BITS-1:0] w_idx;
  logic [RAM_ADDR_BITS-1:0] w_addr;
  logic                     w_drop;

  generate
    if (RAM_WIDTH > SAMPLE_WIDTH) begin : g_sext_pad
      assign w_sext = {{(RAM_WIDTH-SAMPLE_WIDTH){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
    end else begin : g_sext_none
      assign w_sext = sample_in;
    end
  endgenerate

  assign w_idx = fill_q[RAM_ADDR_BITS-1:0];

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    w_addr = '0;
    for (int i = 0; i < RAM_ADDR_BITS; i++) begin
      w_addr[i] = w_idx[RAM_ADDR_BITS-1-i];
    end
  end
`else
  assign w_addr = w_idx;
`endif

  // The address is issued with the sample; data and write enable follow one
  // cycle later through the pend_* stage, matching the RAM's registered address.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    addr_d     = addr_q;
    pend_d     = 1'b0;
    pend_din_d = pend_din_q;
    w_drop     = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (capture_en) begin
          state_d = c_FILL;
          fill_d  = '0;
        end else begin
          w_drop = sample_valid;
        end
      end
      c_FILL: begin
        if (!capture_en) begin
          state_d = c_IDLE;
          fill_d  = '0;
          w_drop  = sample_valid;
        end else if (sample_valid) begin
          addr_d     = w_addr;
          pend_d     = 1'b1;
          pend_din_d = w_sext;
          fill_d     = fill_q + 1'b1;
          if (fill_q == c_LAST) begin
            state_d = c_FLUSH;
          end
        end
      end
      c_FLUSH: begin
        w_drop = sample_valid;
        // Leave once the final write has moved onto ram_we.
        if (!pend_q) begin
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        w_drop = sample_valid;
        if (fft_ack) begin
          state_d = c_IDLE;
          fill_d  = '0;
        end
      end
      default: state_d = c_IDLE;
    endcase
    drop_d = (w_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= c_IDLE;
      fill_q     <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      pend_din_q <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_din_q <= pend_din_d;
      din_q      <= pend_din_q;
      we_q       <= pend_q;
      drop_q     <= drop_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign ram_we      = we_q;
  assign frame_ready = (state_q == c_DONE);
  assign busy        = (state_q == c_FILL) || (state_q == c_FLUSH);
  assign fill_count  = fill_q;
  assign drop_count  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_input_loader.sv
// +----------------------------------------------------------------------------+
// | tb_fft_input_loader                                                        |
// | Directed, table-driven bench for fft_input_loader.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fft_input_loader;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        fft_ack = 1'b0;
  logic [9:0]  ram_addr;
  logic [17:0] ram_din;
  logic        ram_we;
  logic        frame_ready;
  logic        busy;
  logic [10:0] fill_count;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_bad = 0;

  fft_input_loader dut (
    .Clk          (Clk),
    .reset        (reset),
    .capture_en   (capture_en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft_ack      (fft_ack),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .fill_count   (fill_count),
    .drop_count   (drop_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          idx;
    logic [11:0] smp;
    logic [9:0]  addr_br;
    logic [9:0]  addr_nat;
    logic [17:0] din;
  } vec_t;

  vec_t        vt [7];
  logic [11:0] smp_a [1024];
  logic [9:0]  exp_a [1024];
  logic [17:0] exp_d [1024];

  function automatic logic [9:0] ref_addr(input int i);
    logic [9:0] v;
    logic [9:0] r;
    v = 10'(i);
    r = '0;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < 10; b++) r[b] = v[9-b];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vt[0] = '{0,    12'h000, 10'd0,    10'd0,    18'h00000};
    vt[1] = '{1,    12'h001, 10'd512,  10'd1,    18'h00001};
    vt[2] = '{3,    12'h003, 10'd768,  10'd3,    18'h00003};
    vt[3] = '{5,    12'h800, 10'd640,  10'd5,    18'h3F800};
    vt[4] = '{6,    12'h7FF, 10'd384,  10'd6,    18'h007FF};
    vt[5] = '{512,  12'hA5A, 10'd1,    10'd512,  18'h3FA5A};
    vt[6] = '{1023, 12'h3FF, 10'd1023, 10'd1023, 18'h003FF};

    for (int i = 0; i < 1024; i++) begin
      smp_a[i] = 12'(i);
      exp_a[i] = ref_addr(i);
      exp_d[i] = {6'b0, 12'(i)};
    end
    foreach (vt[k]) begin
      smp_a[vt[k].idx] = vt[k].smp;
`ifdef FFT_LOADER_BITREV_EN
      exp_a[vt[k].idx] = vt[k].addr_br;
`else
      exp_a[vt[k].idx] = vt[k].addr_nat;
`endif
      exp_d[vt[k].idx] = vt[k].din;
    end

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_ready", 32'(frame_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Full frame, back-to-back strobes
    capture_en = 1'b1;
    tick();
    chk("fill_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 1024; i++) begin
      sample_valid = 1'b1;
      sample_in    = smp_a[i];
      tick();
      chk("frm_addr", 32'(ram_addr), 32'(exp_a[i]));
      chk("frm_fill", 32'(fill_count), 32'(i + 1));
      if (i > 0) begin
        chk("frm_we", 32'(ram_we), 32'd1);
        chk("frm_din", 32'(ram_din), 32'(exp_d[i-1]));
      end
    end
    sample_valid = 1'b0;
    tick();
    chk("last_we", 32'(ram_we), 32'd1);
    chk("last_din", 32'(ram_din), 32'(exp_d[1023]));
    chk("flush_ready", 32'(frame_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    tick();
    chk("done_ready", 32'(frame_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_we", 32'(ram_we), 32'd0);
    chk("done_fill", 32'(fill_count), 32'd1024);

    // Strobes while frame_ready are dropped
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in    = 12'h155;
      tick();
      chk("drop_we", 32'(ram_we), 32'd0);
    end
    sample_valid = 1'b0;
    tick();
    chk("drop_cnt5", 32'(drop_count), 32'd5);
    chk("drop_hold", 32'(frame_ready), 32'd1);

    // Acknowledge, then the next frame enters FILL one cycle later
    fft_ack = 1'b1;
    tick();
    fft_ack = 1'b0;
    chk("ack_ready", 32'(frame_ready), 32'd0);
    chk("ack_fill", 32'(fill_count), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    tick();
    chk("refill_busy", 32'(busy), 32'd1);

    // 300 samples, a stray fft_ack mid-FILL, then abort
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      sample_in    = 12'(i);
      fft_ack      = (i == 100);
      tick();
      chk("p_addr", 32'(ram_addr), 32'(ref_addr(i)));
      chk("p_fill", 32'(fill_count), 32'(i + 1));
      if (i > 0) begin
        chk("p_din", 32'(ram_din), 32'(i - 1));
      end
    end
    fft_ack      = 1'b0;
    sample_valid = 1'b0;
    capture_en   = 1'b0;
    tick();
    chk("abort_we", 32'(ram_we), 32'd1);
    chk("abort_din", 32'(ram_din), 32'd299);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fill", 32'(fill_count), 32'd0);
    tick();
    chk("abort_we2", 32'(ram_we), 32'd0);
    chk("abort_ready", 32'(frame_ready), 32'd0);
    chk("abort_drop", 32'(drop_count), 32'd5);

    // Restart at index 0, then reset one cycle after a strobe
    capture_en = 1'b1;
    tick();
    sample_valid = 1'b1;
    sample_in    = 12'hFFF;
    tick();
    sample_valid = 1'b0;
    chk("rs_addr", 32'(ram_addr), 32'd0);
    chk("rs_fill", 32'(fill_count), 32'd1);
    reset = 1'b1;
    tick();
    chk("mr_we", 32'(ram_we), 32'd0);
    chk("mr_addr", 32'(ram_addr), 32'd0);
    chk("mr_din", 32'(ram_din), 32'd0);
    chk("mr_fill", 32'(fill_count), 32'd0);
    chk("mr_drop", 32'(drop_count), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(frame_ready), 32'd0);
    reset      = 1'b0;
    capture_en = 1'b0;
    tick();
    chk("mr_we2", 32'(ram_we), 32'd0);

    // Drop counter saturation
    sample_valid = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 32'(drop_count), 32'hFFFE);
    for (int i = 0; i < 6; i++) tick();
    sample_valid = 1'b0;
    chk("sat_ffff", 32'(drop_count), 32'hFFFF);
    chk("sat_we", 32'(ram_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
